// File: rtl/dm_responder.sv
// Data-memory responder: one load/store at a time with configurable wait cycles and a ready pulse.
// Define DM_WRITE_LOG_EN to print a line for every committed in-range write.
module dm_responder #(
    parameter int unsigned DEPTH_WORDS = 3072,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned LATENCY     = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [3:0]  be,
    input  logic [31:0] wdata,
    input  logic [31:0] pc,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic        busy
);

    localparam int          IW   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [3:0]  LAT  = 4'(LATENCY);

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

    state_t        state;
    logic [3:0]    count;
    logic          phase;
    logic          we_q;
    logic [31:0]   addr_q;
    logic [3:0]    be_q;
    logic [31:0]   wdata_q;
    logic [31:0]   word_q;
    logic [31:0]   mem [DEPTH_WORDS];

    logic [32:0]   diff;
    logic          range_error;
    logic [IW-1:0] idx;
    logic [31:0]   merged;

`ifdef DM_WRITE_LOG_EN
    logic [31:0]   pc_q;
`else
    logic          unused_pc;
    assign unused_pc = ^pc;
`endif

    // 33-bit subtraction: the borrow bit flags addresses below BASE_ADDR without wrap-around
    always_comb begin
        diff        = {1'b0, addr_q} - {1'b0, BASE_ADDR};
        range_error = diff[32] || ({1'b0, diff[31:0]} >= SPAN);
        idx         = diff[IW+1:2];
        merged      = word_q;
        for (int i = 0; i < 4; i++) begin
            if (be_q[i]) begin
                merged[8*i +: 8] = wdata_q[8*i +: 8];
            end
        end
    end

    // ACCESS spends one cycle fetching the word and one cycle merging/committing it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            count   <= '0;
            phase   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            word_q  <= '0;
            rdata   <= '0;
            ready   <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b0;
`ifdef DM_WRITE_LOG_EN
            pc_q    <= '0;
`endif
            for (int i = 0; i < int'(DEPTH_WORDS); i++) begin
                mem[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        we_q    <= we;
                        addr_q  <= addr;
                        be_q    <= be;
                        wdata_q <= wdata;
`ifdef DM_WRITE_LOG_EN
                        pc_q    <= pc;
`endif
                        count   <= LAT;
                        phase   <= 1'b0;
                        busy    <= 1'b1;
                        state   <= (LAT != 4'd0) ? WAIT : ACCESS;
                    end
                end
                WAIT: begin
                    count <= count - 4'd1;
                    if (count <= 4'd1) begin
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!phase) begin
                        if (!range_error) begin
                            word_q <= mem[idx];
                        end
                        phase <= 1'b1;
                    end else begin
                        phase <= 1'b0;
                        ready <= 1'b1;
                        err   <= range_error;
                        state <= RESP;
                        if (range_error) begin
                            rdata <= '0;
                        end else if (we_q) begin
                            mem[idx] <= merged;
                            rdata    <= '0;
`ifdef DM_WRITE_LOG_EN
                            $display("@%h: *%h <= %h", pc_q, {addr_q[31:2], 2'b00}, merged);
`endif
                        end else begin
                            rdata <= word_q;
                        end
                    end
                end
                RESP: begin
                    ready <= 1'b0;
                    err   <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/dm_responder.md
Name: dm_responder

Overview:
- Data-memory responder for the MIPS core: the target end of the core's load/store interface.
- Accepts one request at a time, waits a configurable number of cycles, performs a word read or a byte-enabled write, and returns a one-cycle `ready` pulse with registered read data.
- Sits beside `mips` in the top level and testbench; lets the core and bench exercise multi-cycle memory timing instead of a zero-latency array.

Parameters:
- DEPTH_WORDS, 3072, number of 32-bit words (12 KiB).
- BASE_ADDR, 32'h0000_0000, byte address of word 0.
- LATENCY, 0, extra wait cycles between accept and access (0..15).

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  1  request valid; held stable with all request fields until `ready`.
- we  input  1  1 = write, 0 = read.
- addr  input  32  byte address; addr[1:0] ignored, word index = (addr-BASE_ADDR)>>2.
- be  input  4  byte enables for writes; bit i selects wdata[8i+7:8i].
- wdata  input  32  write data.
- pc  input  32  PC of the issuing instruction, used only for logging.
- rdata  output  32  registered read data, valid while ready=1.
- ready  output  1  one-cycle completion pulse.
- err  output  1  asserted with ready when the address is out of range.
- busy  output  1  high from accept until the cycle after ready.

Behaviour:
- Reset (asynchronous, active-high):
  - rdata=0, ready=0, err=0, busy=0, state=IDLE, wait counter=0.
  - All memory words cleared to 0.
  - Reset mid-transaction abandons the access; a pending write is not committed.
- State machine IDLE -> WAIT -> ACCESS -> RESP -> IDLE:
  - IDLE: on req=1, latch we/addr/be/wdata/pc, load counter with LATENCY, set busy=1. Go to WAIT if LATENCY>0, else ACCESS.
  - WAIT: decrement counter each cycle; go to ACCESS when the counter reaches 1.
  - ACCESS: perform the operation on the latched fields.
    - Read: rdata <= mem[idx].
    - Write: for each set be[i], update byte i; unset bytes are preserved; rdata <= 0.
    - ready<=1 and err<=range_error are registered in this cycle, so both are visible in RESP.
  - RESP: ready=1 for exactly one cycle; next state IDLE with busy=0, ready=0.
- Latency: with req sampled high at edge N, ready is high in the cycle after edge N+2+LATENCY.
  - Minimum throughput: one transaction per 4 cycles at LATENCY=0.
- Request rules:
  - req is ignored when not in IDLE.
  - A req still high in the cycle after RESP is treated as a new request.
  - Changing request fields while busy has no effect (fields are latched at accept).
- Range check: error when addr < BASE_ADDR or (addr-BASE_ADDR) >= 4*DEPTH_WORDS.
  - On error, no memory update, rdata=0, err=1 for the ready cycle.
  - Address arithmetic is unsigned 32-bit; an address below BASE does not wrap into range.
- Write with be=4'b0000 completes normally (ready pulse) but changes nothing.
- Back-to-back write-then-read to the same word: the read returns the merged written value.

Optional Feature:
- Macro DM_WRITE_LOG_EN.
- Defined: at every committed in-range write, during ACCESS, emit `$display("@%h: *%h <= %h", pc, {addr[31:2],2'b00}, merged_word)`. merged_word is the full post-write word. No log for reads, errored writes, or writes abandoned by reset.
- Undefined: no display statements compiled; the `pc` port is unused; all other behaviour identical.

Test Plan:
- Reset then read 0x0000_0010, LATENCY=0 -> ready 3 cycles after accept, rdata=0, err=0.
- Write 0x0000_0004 wdata=0xDEADBEEF be=4'hF, then read 0x4 -> rdata=0xDEADBEEF. With DM_WRITE_LOG_EN and pc=0x3000, log `@00003000: *00000004 <= deadbeef`.
- Partial write, same word: be=4'b0010 wdata=0x0000_5500 -> read gives 0xDEAD55EF. Then be=4'b1100 wdata=0x1234_0000 -> read gives 0x123455EF.
- LATENCY=3: read request -> ready exactly 6 cycles after accept. busy high throughout. Toggling wdata/addr while busy does not change the result.
- Out of range: read at 0x0000_3000 (DEPTH 3072) -> ready with err=1, rdata=0. Write there -> memory unchanged, no log line.
- Reset asserted during WAIT of a write to 0x8 (LATENCY=5) -> outputs zero immediately without a clock edge. After release, read 0x8 returns 0 and no write is logged.
